// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_pkg
//  Purpose  : Shared definitions for the time-keeping register bank: the
//             arbiter state encoding, default snapshot window and the named
//             register addresses used by the RTC, keypad and VGA blocks.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package regbank_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_DONE     = 3'd4
  } arbState_t;

  // Snapshot window: everything the pointer stage draws each frame.
  localparam logic [3:0] DEF_FIRST_ADDR = 4'd1;
  localparam logic [3:0] DEF_LAST_ADDR  = 4'd12;
  localparam int         DEF_RD_LATENCY = 1;

  // Register map.
  localparam logic [3:0] SEG_RELOJ  = 4'd1;
  localparam logic [3:0] MIN_RELOJ  = 4'd2;
  localparam logic [3:0] HOR_RELOJ  = 4'd3;
  localparam logic [3:0] DIA_FECHA  = 4'd4;
  localparam logic [3:0] MES_FECHA  = 4'd5;
  localparam logic [3:0] ANO_FECHA  = 4'd6;
  localparam logic [3:0] SEG_CRONO  = 4'd7;
  localparam logic [3:0] MIN_CRONO  = 4'd8;
  localparam logic [3:0] HOR_CRONO  = 4'd9;
  localparam logic [3:0] RING_CRONO = 4'd10;
  localparam logic [3:0] ACT_CRONO  = 4'd11;
  localparam logic [3:0] CURSOR     = 4'd12;

endpackage
`default_nettype wire

// File: rtl/regbank_ram_arbiter_rd_latency_counter.sv
`default_nettype none
// ============================================================================
//  Module   : rd_latency_counter
//  Purpose  : Loadable down-counter that times the RAM read latency.
//             done is high while the count is zero.
//  Ports    : CLK, RESET (async, active high), load/loadValue (sync load,
//             has priority), dec (decrement, saturates at 0), done.
//  Revision : 1.0 - initial release
// ============================================================================
module rd_latency_counter #(
  parameter int WIDTH = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= loadValue;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/regbank_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_ram_arbiter
//  Purpose  : Owns the single-port 16x8 register RAM. Serves req/ack writes
//             from the RTC/keypad controller and, on every FrameStart, bursts
//             a coherent snapshot of FIRST_ADDR..LAST_ADDR to the VGA pointer
//             bank as SnapValid/SnapAddr/SnapData beats.
//  Ports    : CLK, RESET (async, active high)
//             FrameStart                     - frame pulse, starts a burst
//             WrReq/WrAddr/WrData -> WrAck   - writer handshake
//             RamAddr/RamWrData/RamWE, RamRdData - RAM interface
//             SnapValid/SnapAddr/SnapData/SnapDone - snapshot stream
//             Overrun (sticky), Busy
//  Config   : ARB_INTERLEAVE_EN - when defined, a pending write gets one
//             slot after each snapshot beat instead of waiting for the
//             whole burst.
//  Revision : 1.0 - initial release
// ============================================================================
module regbank_ram_arbiter
  import regbank_pkg::*;
#(
  parameter logic [3:0] FIRST_ADDR = DEF_FIRST_ADDR,
  parameter logic [3:0] LAST_ADDR  = DEF_LAST_ADDR,
  parameter int         RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FrameStart,
  input  logic       WrReq,
  input  logic [3:0] WrAddr,
  input  logic [7:0] WrData,
  output logic       WrAck,
  output logic [3:0] RamAddr,
  output logic [7:0] RamWrData,
  output logic       RamWE,
  input  logic [7:0] RamRdData,
  output logic       SnapValid,
  output logic [3:0] SnapAddr,
  output logic [7:0] SnapData,
  output logic       SnapDone,
  output logic       Overrun,
  output logic       Busy
);

  // RD_WAIT lasts RD_LATENCY cycles; the counter runs down to zero in it.
  localparam logic [1:0] C_WAIT_LOAD = 2'(RD_LATENCY - 1);

  arbState_t  r_state;
  logic [3:0] r_index;
  logic       r_framePend;  // frame arrived during a stand-alone write
  logic       r_inBurst;    // a WRITE slot must return to the burst
  logic       w_waitDone;

  rd_latency_counter #(
    .WIDTH (2)
  ) u_rdLatency (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (r_state == ST_RD_ISSUE),
    .loadValue (C_WAIT_LOAD),
    .dec       (r_state == ST_RD_WAIT),
    .done      (w_waitDone)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_index     <= FIRST_ADDR;
      r_framePend <= 1'b0;
      r_inBurst   <= 1'b0;
      WrAck       <= 1'b0;
      RamAddr     <= 4'd0;
      RamWrData   <= 8'd0;
      RamWE       <= 1'b0;
      SnapValid   <= 1'b0;
      SnapAddr    <= 4'd0;
      SnapData    <= 8'd0;
      SnapDone    <= 1'b0;
      Overrun     <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      // Pulse outputs default low; each branch raises what it owns.
      WrAck     <= 1'b0;
      RamWE     <= 1'b0;
      SnapValid <= 1'b0;
      SnapDone  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (FrameStart || r_framePend) begin
            r_state     <= ST_RD_ISSUE;
            r_framePend <= 1'b0;
            r_inBurst   <= 1'b1;
            r_index     <= FIRST_ADDR;
            RamAddr     <= FIRST_ADDR;
            Busy        <= 1'b1;
          end else if (WrReq) begin
            r_state   <= ST_WRITE;
            RamAddr   <= WrAddr;
            RamWrData <= WrData;
            RamWE     <= 1'b1;
            WrAck     <= 1'b1;
            Busy      <= 1'b1;
          end
        end

        ST_WRITE: begin
          // A frame during an interleaved slot belongs to the running burst.
          if (FrameStart) begin
            if (r_inBurst) begin
              Overrun <= 1'b1;
            end else begin
              r_framePend <= 1'b1;
            end
          end
          if (r_inBurst) begin
            r_state <= ST_RD_ISSUE;
            RamAddr <= r_index;
            Busy    <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            Busy    <= 1'b0;
          end
        end

        ST_RD_ISSUE: begin
          if (FrameStart) Overrun <= 1'b1;
          r_state <= ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          if (FrameStart) Overrun <= 1'b1;
          if (w_waitDone) begin
            SnapValid <= 1'b1;
            SnapAddr  <= r_index;
            SnapData  <= RamRdData;
            // Compare before incrementing so LAST_ADDR=15 never wraps.
            if (r_index == LAST_ADDR) begin
              r_state   <= ST_DONE;
              r_inBurst <= 1'b0;
              SnapDone  <= 1'b1;
            end else begin
              r_index <= r_index + 4'd1;
`ifdef ARB_INTERLEAVE_EN
              if (WrReq) begin
                r_state   <= ST_WRITE;
                RamAddr   <= WrAddr;
                RamWrData <= WrData;
                RamWE     <= 1'b1;
                WrAck     <= 1'b1;
              end else begin
                r_state <= ST_RD_ISSUE;
                RamAddr <= r_index + 4'd1;
              end
`else
              r_state <= ST_RD_ISSUE;
              RamAddr <= r_index + 4'd1;
`endif
            end
          end
        end

        ST_DONE: begin
          if (FrameStart) Overrun <= 1'b1;
          // A writer held off by the burst is granted straight away.
          if (WrReq) begin
            r_state   <= ST_WRITE;
            RamAddr   <= WrAddr;
            RamWrData <= WrData;
            RamWE     <= 1'b1;
            WrAck     <= 1'b1;
            Busy      <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            Busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regbank_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regbank_ram_arbiter
//  Purpose  : Directed self-checking bench. Instance A uses the default
//             window (1..12, latency 1); instance B uses 13..15, latency 3.
//             Each instance drives a behavioural RAM with matching latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_ram_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET;

  // Instance A signals
  logic       frameA, wrReqA, wrAckA, ramWEA, snapValidA, snapDoneA, overrunA, busyA;
  logic [3:0] wrAddrA, ramAddrA, snapAddrA;
  logic [7:0] wrDataA, ramWrDataA, ramRdDataA, snapDataA;
  // Instance B signals
  logic       frameB, wrReqB, wrAckB, ramWEB, snapValidB, snapDoneB, overrunB, busyB;
  logic [3:0] wrAddrB, ramAddrB, snapAddrB;
  logic [7:0] wrDataB, ramWrDataB, ramRdDataB, snapDataB;

  regbank_ram_arbiter dutA (
    .CLK(CLK), .RESET(RESET), .FrameStart(frameA), .WrReq(wrReqA), .WrAddr(wrAddrA),
    .WrData(wrDataA), .WrAck(wrAckA), .RamAddr(ramAddrA), .RamWrData(ramWrDataA),
    .RamWE(ramWEA), .RamRdData(ramRdDataA), .SnapValid(snapValidA), .SnapAddr(snapAddrA),
    .SnapData(snapDataA), .SnapDone(snapDoneA), .Overrun(overrunA), .Busy(busyA)
  );

  regbank_ram_arbiter #(.FIRST_ADDR(4'd13), .LAST_ADDR(4'd15), .RD_LATENCY(3)) dutB (
    .CLK(CLK), .RESET(RESET), .FrameStart(frameB), .WrReq(wrReqB), .WrAddr(wrAddrB),
    .WrData(wrDataB), .WrAck(wrAckB), .RamAddr(ramAddrB), .RamWrData(ramWrDataB),
    .RamWE(ramWEB), .RamRdData(ramRdDataB), .SnapValid(snapValidB), .SnapAddr(snapAddrB),
    .SnapData(snapDataB), .SnapDone(snapDoneB), .Overrun(overrunB), .Busy(busyB)
  );

  // Behavioural RAMs: A has 1-cycle read latency, B has 3.
  logic       preload;
  logic [7:0] memA [16];
  logic [7:0] memB [16];
  logic [7:0] pipeB1, pipeB2;

  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) begin
        memA[i] <= 8'(i * 3);
        memB[i] <= 8'(i * 3);
      end
    end else begin
      if (ramWEA) memA[ramAddrA] <= ramWrDataA;
      if (ramWEB) memB[ramAddrB] <= ramWrDataB;
    end
    ramRdDataA <= memA[ramAddrA];
    pipeB1     <= memB[ramAddrB];
    pipeB2     <= pipeB1;
    ramRdDataB <= pipeB2;
  end

  // Expected RAM contents, maintained from the writes the bench issues.
  logic [7:0] expA [16];
  logic [7:0] expB [16];

  // Output view of the instance under test.
  logic       sel;
  logic       mValid, mDone, mAck, mOverrun, mBusy;
  logic [3:0] mAddr;
  logic [7:0] mData;
  assign mValid   = sel ? snapValidB : snapValidA;
  assign mDone    = sel ? snapDoneB  : snapDoneA;
  assign mAck     = sel ? wrAckB     : wrAckA;
  assign mOverrun = sel ? overrunB   : overrunA;
  assign mBusy    = sel ? busyB      : busyA;
  assign mAddr    = sel ? snapAddrB  : snapAddrA;
  assign mData    = sel ? snapDataB  : snapDataA;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic setFrame(input logic v);
    if (sel) frameB = v; else frameA = v;
  endtask

  // Pulse FrameStart (optionally with a write request on A), then follow
  // the burst for a fixed number of cycles. Cycle n=1 is the first cycle
  // after the edge that sampled FrameStart; beat k is expected at
  // n = period*k + 1 and SnapDone alongside the last beat.
  task automatic runBurst(input int first, input int last, input int period,
                          input int frameAgainAt, input bit withWr,
                          input logic [3:0] wAddr, input logic [7:0] wData,
                          input bit expectOverrun);
    int nBeats    = last - first + 1;
    int beats     = 0;
    int doneCycle = -1;
    int ackCycle  = -1;
    logic [3:0] ea;
    logic [7:0] ed;
    setFrame(1'b1);
    if (withWr) begin
      wrAddrA = wAddr;
      wrDataA = wData;
      wrReqA  = 1'b1;
    end
    tick();
    for (int n = 1; n <= period * nBeats + 4; n++) begin
      setFrame(n == frameAgainAt);
      if (mValid) begin
        beats++;
        ea = 4'(first + beats - 1);
        ed = sel ? expB[ea] : expA[ea];
        chk("beat_addr", mAddr, ea);
        chk("beat_data", mData, ed);
        chk("beat_cycle", n, period * beats + 1);
      end
      if (mDone && doneCycle < 0) doneCycle = n;
      if (withWr && mAck && ackCycle < 0) begin
        ackCycle = n;
        wrReqA   = 1'b0;
        expA[wAddr] = wData;
      end
      tick();
    end
    chk("beat_count", beats, nBeats);
    chk("done_cycle", doneCycle, period * nBeats + 1);
    if (withWr) chk("ack_after_done", ackCycle, period * nBeats + 2);
    if (expectOverrun) chk("overrun_set", mOverrun, 1);
    chk("idle_after_burst", mBusy, 0);
  endtask

  initial begin
    RESET   = 1'b1;
    preload = 1'b1;
    sel     = 1'b0;
    frameA = 1'b0; wrReqA = 1'b0; wrAddrA = 4'd0; wrDataA = 8'd0;
    frameB = 1'b0; wrReqB = 1'b0; wrAddrB = 4'd0; wrDataB = 8'd0;
    for (int i = 0; i < 16; i++) begin
      expA[i] = 8'(i * 3);
      expB[i] = 8'(i * 3);
    end
    repeat (3) tick();

    // Reset state
    chk("rst_wrack", wrAckA, 0);
    chk("rst_ramwe", ramWEA, 0);
    chk("rst_ramaddr", ramAddrA, 0);
    chk("rst_snapvalid", snapValidA, 0);
    chk("rst_snapdone", snapDoneA, 0);
    chk("rst_overrun", overrunA, 0);
    chk("rst_busy", busyA, 0);
    chk("rst_busyB", busyB, 0);

    preload = 1'b0;
    RESET   = 1'b0;
    tick();

    // Full burst from preloaded RAM (data 3..36)
    runBurst(1, 12, 2, 0, 1'b0, 4'd0, 8'd0, 1'b0);
    chk("no_overrun", overrunA, 0);

    // Write in IDLE: addr 5 <- 0x42
    wrAddrA = 4'd5; wrDataA = 8'h42; wrReqA = 1'b1;
    tick();
    chk("wr_ack", wrAckA, 1);
    chk("wr_we", ramWEA, 1);
    chk("wr_addr", ramAddrA, 5);
    chk("wr_data", ramWrDataA, 8'h42);
    wrReqA = 1'b0;
    expA[5] = 8'h42;
    tick();
    chk("wr_ack_clear", wrAckA, 0);
    chk("wr_we_clear", ramWEA, 0);
    chk("wr_idle", busyA, 0);
    tick();
    runBurst(1, 12, 2, 0, 1'b0, 4'd0, 8'd0, 1'b0);

    // FrameStart and WrReq together: burst first, write right after DONE
    runBurst(1, 12, 2, 0, 1'b1, 4'd2, 8'h77, 1'b0);
    tick();
    chk("wr_mem2", memA[2], 8'h77);

    // Second FrameStart while beat 6 is on the bus
    runBurst(1, 12, 2, 13, 1'b0, 4'd0, 8'd0, 1'b1);
    repeat (3) tick();
    chk("overrun_sticky", overrunA, 1);

    // Reset in the middle of a burst (beat 5)
    frameA = 1'b1;
    tick();
    frameA = 1'b0;
    repeat (10) tick();
    chk("mid_beat5_valid", snapValidA, 1);
    chk("mid_beat5_addr", snapAddrA, 5);
    #2 RESET = 1'b1;
    #1;
    chk("abort_valid", snapValidA, 0);
    chk("abort_addr", snapAddrA, 0);
    chk("abort_data", snapDataA, 0);
    chk("abort_busy", busyA, 0);
    chk("abort_ramaddr", ramAddrA, 0);
    chk("abort_overrun", overrunA, 0);
    @(negedge CLK);
    chk("abort_nodone", snapDoneA, 0);
    RESET = 1'b0;
    tick();
    runBurst(1, 12, 2, 0, 1'b0, 4'd0, 8'd0, 1'b0);

    // Instance B: window 13..15, latency 3, no index wrap
    sel = 1'b1;
    runBurst(13, 15, 4, 0, 1'b0, 4'd0, 8'd0, 1'b0);
    chk("B_ramaddr_nowrap", ramAddrB, 15);
    chk("B_snapaddr_last", snapAddrB, 15);
    runBurst(13, 15, 4, 0, 1'b0, 4'd0, 8'd0, 1'b0);
    chk("B_no_overrun", overrunB, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
